mod_pipe_param: RTL
===================

Name: mod_pipe_param

Overview:
Parametrised, multi-channel, registered stream pipeline with a valid/ready handshake. It is the sequential successor of the team's parametrised passthrough block. It carries CHANNELS lanes of WIDTH-bit data, packed per lane and grouped in an unpacked array, through DEPTH elastic register stages. It adds synchronous flush, an occupancy report, a transfer counter and optional per-lane sign extension on the output. It sits between producer and consumer blocks wherever fixed-latency, backpressure-safe buffering is needed.

Parameters:
WIDTH, 8, bits per lane at input (int, >=1)
OWIDTH, 8, bits per lane at output (int, >=WIDTH); upper bits are zero- or sign-filled
CHANNELS, 4, number of lanes (int, >=1)
DEPTH, 2, number of register stages (int, 1..8)
SIGNED_EXT, 1'b0, bit: 1 = sign-extend lanes to OWIDTH, 0 = zero-extend
CNT_W, 16, width of the transfer counter (int, 1..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline clear
in_valid  input  1  input beat present
in_ready  output  1  pipeline can accept a beat
in_data  input  [WIDTH-1:0] x [CHANNELS]  input lanes (unpacked array of packed vectors)
out_valid  output  1  output beat present
out_ready  input  1  consumer accepts the beat
out_data  output  [OWIDTH-1:0] x [CHANNELS]  output lanes, extended per SIGNED_EXT
occupancy  output  $clog2(DEPTH+1)  number of valid stages
xfer_count  output  CNT_W  count of completed output transfers

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset clears every stage valid bit and every stage data register to 0. After reset: out_valid=0, out_data=all 0, occupancy=0, xfer_count=0, in_ready=1.
- Stage k (0..DEPTH-1) holds valid_k and data_k. Stage 0 is fed from the input; stage DEPTH-1 drives the output.
- Stage ready rules:
  - ready_k = !valid_k || ready_(k+1).
  - ready_DEPTH = out_ready.
  - in_ready = ready_0 && !flush.
  - The ready chain is combinational; there are no bubbles at full throughput.
- Stage load rule: stage k loads from stage k-1 (stage 0 loads from in_data/in_valid) when ready_k=1. The loaded valid equals the upstream valid. Data registers load only when the upstream valid is 1; otherwise they hold their value.
- Input transfer occurs on in_valid && in_ready. Output transfer occurs on out_valid && out_ready.
- Latency: with out_ready held high, a beat accepted in cycle t appears at out_valid in cycle t+DEPTH. Sustained throughput is 1 beat/cycle.
- Backpressure:
  - When out_ready=0, out_valid and out_data hold stable.
  - Empty stages keep filling until all DEPTH stages are valid; then in_ready=0.
  - in_data is not sampled while in_ready=0.
- Extension: out_data lane i is data_(DEPTH-1) lane i, extended to OWIDTH. The fill is the lane MSB when SIGNED_EXT=1, otherwise zeros. When OWIDTH=WIDTH the lane passes unchanged.
- Flush:
  - At the edge, all valid bits clear, so occupancy=0 and out_valid=0 in the next cycle. Data registers are unaffected.
  - During the flush cycle in_ready=0, so no input beat is accepted.
  - An output transfer that coincides with flush (out_valid && out_ready in that cycle) still counts in xfer_count.
- rst has priority over flush.
- occupancy: registered population count of the valid bits, updated every cycle. It is never greater than DEPTH.
- xfer_count increments by 1 on each output transfer and wraps modulo 2^CNT_W. Only rst clears it; flush does not.
- Reset mid-operation: all in-flight beats are discarded, with no output transfer in the reset cycle's aftermath. out_valid=0 from the next cycle.
- Simultaneous input and output transfer while full: allowed. Occupancy stays DEPTH.

Test Plan:
1. Latency: rst high for 2 cycles, then DEPTH=2, out_ready=1; send lane0=8'h11, lane3=8'h44 at cycle 5 -> out_valid=1 at cycle 7 with lane0=8'h11 and lane3=8'h44; occupancy 1 in cycles 6 and 7; xfer_count=1.
2. Stream: 10 back-to-back beats with data 0..9, out_ready=1 -> in_ready stays 1; outputs are 0..9 in order on consecutive cycles; xfer_count=10.
3. Backpressure: DEPTH=3, out_ready=0, 5 beats offered -> 3 accepted, in_ready=0, occupancy=3, out_data stable. Then out_ready=1 -> the 3 beats drain in order and the remaining 2 follow with no gap.
4. Sign extension: WIDTH=8, OWIDTH=12, SIGNED_EXT=1, lane=8'h80 -> 12'hF80. With SIGNED_EXT=0 -> 12'h080.
5. Flush: pipeline full (occupancy=2) with out_ready=0; pulse flush for 1 cycle alongside in_valid=1 -> next cycle occupancy=0, out_valid=0; the beat offered in the flush cycle is lost; xfer_count unchanged.
6. Wrap and reset: CNT_W=4, complete 17 transfers -> xfer_count=1. Assert rst mid-stream -> next cycle out_valid=0, occupancy=0, xfer_count=0.

Source files
------------

// File: rtl/mod_pipe_param.sv
// mod_pipe_param: multi-lane elastic register pipeline with valid/ready handshake.
// DEPTH stages carry CHANNELS lanes of WIDTH bits. Output lanes are widened to
// OWIDTH with a sign or zero fill. Also provides a synchronous flush, a
// registered occupancy count and a wrapping count of output transfers.
module mod_pipe_param #(
  parameter int WIDTH      = 8,
  parameter int OWIDTH     = 8,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 2,
  parameter bit SIGNED_EXT = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data    [CHANNELS],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OWIDTH-1:0]            out_data   [CHANNELS],
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             xfer_count
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH][CHANNELS];
  logic [WIDTH-1:0] data_d [DEPTH][CHANNELS];
  logic [DEPTH-1:0] stage_ready;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  // Number of set bits in a stage-valid vector.
  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + OCC_W'(v[k]);
    end
    return cnt;
  endfunction

  // Ready chain, walked from the consumer back towards the input.
  always_comb begin
    logic r;
    // NOTE: combinational blocks use blocking '=' so each statement sees the
    // value produced by the previous one; clocked blocks use '<=' instead.
    r           = out_ready;
    stage_ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r              = !valid_q[k] || r;
      stage_ready[k] = r;
    end
  end

  assign in_ready  = stage_ready[0] && !flush;
  assign out_valid = valid_q[DEPTH-1];

  // Next state: each ready stage takes its upstream neighbour; flush drops all valids.
  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    xfer_d  = xfer_q;

    if (flush) begin
      // Data registers are left alone; only the valid bits are dropped.
      valid_d = '0;
    end else begin
      if (stage_ready[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (stage_ready[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
    end

    // A transfer on the flush cycle still completes and is counted.
    if (out_valid && out_ready) begin
      xfer_d = xfer_q + CNT_W'(1);
    end

    occ_d = popcount(valid_d);
  end

  // State registers with synchronous, active-high reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the data stages are reset too (not only the valids) because
      // out_data must read all-zero straight after reset.
      data_q  <= '{default: '0};
      occ_q   <= '0;
      xfer_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      xfer_q  <= xfer_d;
    end
  end

  assign occupancy  = occ_q;
  assign xfer_count = xfer_q;

  // Per-lane widening of the last stage to OWIDTH.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    if (OWIDTH > WIDTH) begin : g_ext
      assign out_data[i] = {{(OWIDTH - WIDTH){SIGNED_EXT && data_q[DEPTH-1][i][WIDTH-1]}},
                            data_q[DEPTH-1][i]};
    end else begin : g_pass
      assign out_data[i] = data_q[DEPTH-1][i];
    end
  end

endmodule
